// File: rtl/cpu_pkg.sv
// Shared widths and run-control state encoding for the memory/run-control stage.
package cpu_pkg;
    localparam int INSTRUC_SIZE = 32;
    localparam int ARG_SIZE     = 8;
    localparam int DATA_SIZE    = 8;
    localparam int CNT_WIDTH    = 16;

    typedef enum logic [2:0] {
        RESET_CORE = 3'd0,
        LOAD       = 3'd1,
        START      = 3'd2,
        RUN        = 3'd3,
        HALTED     = 3'd4
    } state_e;
endpackage

// File: rtl/cpu_mem_host_if.sv
// Host port plus core-facing memory/run-control signals of cpu_mem_host.
interface cpu_mem_host_if;
    import cpu_pkg::*;

    logic                    host_we;
    logic                    host_sel;
    logic [ARG_SIZE-1:0]     host_addr;
    logic [INSTRUC_SIZE-1:0] host_wdata;
    logic [INSTRUC_SIZE-1:0] host_rdata;
    logic                    host_go;
    logic                    host_ack;
    logic                    busy;
    logic                    halted;
    logic                    timeout;
    logic [CNT_WIDTH-1:0]    cycles;
    logic                    core_reset;
    logic                    core_start;
    logic                    core_ack;
    logic                    core_done;
    logic [ARG_SIZE-1:0]     pc;
    logic [INSTRUC_SIZE-1:0] instruc;
    logic                    rdEn;
    logic                    wrEn;
    logic [ARG_SIZE-1:0]     addr;
    logic [DATA_SIZE-1:0]    wrData;
    logic [DATA_SIZE-1:0]    rdData;

    modport slave (
        input  host_we, host_sel, host_addr, host_wdata, host_go, host_ack,
               core_done, pc, rdEn, wrEn, addr, wrData,
        output host_rdata, busy, halted, timeout, cycles,
               core_reset, core_start, core_ack, instruc, rdData
    );

    modport master (
        output host_we, host_sel, host_addr, host_wdata, host_go, host_ack,
               core_done, pc, rdEn, wrEn, addr, wrData,
        input  host_rdata, busy, halted, timeout, cycles,
               core_reset, core_start, core_ack, instruc, rdData
    );
endinterface

// File: rtl/cpu_sync_ram.sv
// Single write port, single registered read port RAM; a same-address read and write return the old word.
module cpu_sync_ram #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/cpu_mem_host.sv
// Instruction/data memories, host load port and run-control FSM with watchdog for the Operate core.
// All memory reads have 1-cycle latency; outputs hold their last value when their port is not read.
module cpu_mem_host
    import cpu_pkg::*;
#(
    parameter logic [CNT_WIDTH-1:0] MAX_CYCLES = 16'hFFFF
) (
    input  logic           clk,
    input  logic           reset,
    cpu_mem_host_if.slave  bus
);
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
    logic                 timeout_q, timeout_d;
    logic                 imem_host_q, imem_host_d, imem_core_q, imem_core_d;
    logic                 dmem_host_q, dmem_host_d, dmem_core_q, dmem_core_d;
    logic [INSTRUC_SIZE-1:0] instruc_hold_q, host_rdata_hold_q;
    logic [DATA_SIZE-1:0]    rddata_hold_q;

    logic                    host_win, in_load, in_run;
    logic                    imem_we, dmem_we, dmem_re;
    logic [ARG_SIZE-1:0]     imem_raddr, dmem_raddr, dmem_waddr;
    logic [DATA_SIZE-1:0]    dmem_wdata, dmem_rdata, rddata_w;
    logic [INSTRUC_SIZE-1:0] imem_rdata, instruc_w, host_rdata_w;

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        unique case (state_q)
            RESET_CORE: state_d = LOAD;
            LOAD: begin
                if (bus.host_go) begin
                    state_d   = START;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            START: state_d = RUN;
            RUN: begin
                if (cycles_q != MAX_CYCLES) cycles_d = cycles_q + 1'b1;
                // done on the watchdog's last cycle still counts as a clean halt
                if (bus.core_done) begin
                    state_d = HALTED;
                end else if (cycles_q == MAX_CYCLES - 1'b1) begin
                    timeout_d = 1'b1;
                    state_d   = RESET_CORE;
                end
            end
            HALTED: if (bus.host_ack) state_d = LOAD;
            default: state_d = RESET_CORE;
        endcase
    end

    // The host borrows the read ports only while the core is idle (LOAD/HALTED).
    assign host_win    = (state_q == LOAD) || (state_q == HALTED);
    assign in_load     = (state_q == LOAD);
    assign in_run      = (state_q == RUN);
    assign imem_host_d = host_win && !bus.host_sel;
    assign imem_core_d = !imem_host_d;
    assign dmem_host_d = host_win && bus.host_sel;
    assign dmem_core_d = !dmem_host_d && bus.rdEn;

    assign imem_we    = in_load && bus.host_we && !bus.host_sel;
    assign imem_raddr = imem_host_d ? bus.host_addr : bus.pc;
    assign dmem_we    = (in_load && bus.host_we && bus.host_sel) || (in_run && bus.wrEn);
    assign dmem_waddr = in_run ? bus.addr : bus.host_addr;
    assign dmem_wdata = in_run ? bus.wrData : bus.host_wdata[DATA_SIZE-1:0];
    assign dmem_re    = dmem_host_d || bus.rdEn;
    assign dmem_raddr = dmem_host_d ? bus.host_addr : bus.addr;

    cpu_sync_ram #(.WIDTH(INSTRUC_SIZE), .DEPTH_LOG2(ARG_SIZE)) u_imem (
        .clk(clk), .we(imem_we), .waddr(bus.host_addr), .wdata(bus.host_wdata),
        .re(1'b1), .raddr(imem_raddr), .rdata(imem_rdata)
    );

    cpu_sync_ram #(.WIDTH(DATA_SIZE), .DEPTH_LOG2(ARG_SIZE)) u_dmem (
        .clk(clk), .we(dmem_we), .waddr(dmem_waddr), .wdata(dmem_wdata),
        .re(dmem_re), .raddr(dmem_raddr), .rdata(dmem_rdata)
    );

    assign instruc_w    = imem_core_q ? imem_rdata : instruc_hold_q;
    assign rddata_w     = dmem_core_q ? dmem_rdata : rddata_hold_q;
    assign host_rdata_w = imem_host_q ? imem_rdata :
                          dmem_host_q ? {{(INSTRUC_SIZE-DATA_SIZE){1'b0}}, dmem_rdata} :
                          host_rdata_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= RESET_CORE;
            cycles_q          <= '0;
            timeout_q         <= 1'b0;
            imem_host_q       <= 1'b0;
            imem_core_q       <= 1'b0;
            dmem_host_q       <= 1'b0;
            dmem_core_q       <= 1'b0;
            instruc_hold_q    <= '0;
            rddata_hold_q     <= '0;
            host_rdata_hold_q <= '0;
        end else begin
            state_q           <= state_d;
            cycles_q          <= cycles_d;
            timeout_q         <= timeout_d;
            imem_host_q       <= imem_host_d;
            imem_core_q       <= imem_core_d;
            dmem_host_q       <= dmem_host_d;
            dmem_core_q       <= dmem_core_d;
            instruc_hold_q    <= instruc_w;
            rddata_hold_q     <= rddata_w;
            host_rdata_hold_q <= host_rdata_w;
        end
    end

    assign bus.instruc    = instruc_w;
    assign bus.rdData     = rddata_w;
    assign bus.host_rdata = host_rdata_w;
    assign bus.busy       = (state_q == START) || in_run;
    assign bus.halted     = (state_q == HALTED);
    assign bus.timeout    = timeout_q;
    assign bus.cycles     = cycles_q;
    assign bus.core_reset = (state_q == RESET_CORE);
    assign bus.core_start = (state_q == START);
    assign bus.core_ack   = (state_q == HALTED) && bus.host_ack;
endmodule

// File: tb/tb_cpu_mem_host.sv
// Directed bench for cpu_mem_host: the bench plays both host and core.
module tb_cpu_mem_host;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    cpu_mem_host_if bus();

    cpu_mem_host #(.MAX_CYCLES(16'd16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] OP_LDC_5_7 = 32'h0C050700;
    localparam logic [31:0] OP_HALT    = 32'h3F000000;
    localparam logic [31:0] OP_JMP_0   = 32'h08000000;

    typedef struct {
        logic        we;
        logic        sel;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        reset = 1'b1;
        bus.host_we = 0; bus.host_sel = 0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.host_go = 0; bus.host_ack = 0; bus.core_done = 0; bus.pc = '0;
        bus.rdEn = 0; bus.wrEn = 0; bus.addr = '0; bus.wrData = '0;

        vecs[0]  = '{1'b1, 1'b0, 8'd3, 32'h0C050700, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 8'd9, 32'h000000A5, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 8'd3, 32'h0,        1'b1, 32'h0C050700};
        vecs[3]  = '{1'b0, 1'b1, 8'd9, 32'h0,        1'b1, 32'h000000A5};
        vecs[4]  = '{1'b1, 1'b0, 8'd3, 32'hDEADBEEF, 1'b1, 32'h0C050700};
        vecs[5]  = '{1'b0, 1'b0, 8'd3, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 1'b1, 8'd9, 32'h12345666, 1'b1, 32'h000000A5};
        vecs[7]  = '{1'b0, 1'b1, 8'd9, 32'h0,        1'b1, 32'h00000066};
        vecs[8]  = '{1'b1, 1'b1, 8'd4, 32'h00000011, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 8'd5, 32'h00000000, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 8'd0, OP_LDC_5_7,   1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 8'd1, OP_HALT,      1'b0, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 8'd4, 32'h0,        1'b1, 32'h00000011};
        vecs[13] = '{1'b0, 1'b0, 8'd3, 32'h0,        1'b1, 32'hDEADBEEF};

        // Reset held for two cycles
        tick(); tick();
        check("rst_core_reset", 32'(bus.core_reset), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cycles", 32'(bus.cycles), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        check("rst_core_start", 32'(bus.core_start), 32'd0);
        check("rst_host_rdata", bus.host_rdata, 32'd0);
        check("rst_instruc", bus.instruc, 32'd0);
        check("rst_rddata", 32'(bus.rdData), 32'd0);
        reset = 1'b0;
        #1 check("post_rst_core_reset", 32'(bus.core_reset), 32'd1);
        tick();
        check("load_core_reset", 32'(bus.core_reset), 32'd0);
        check("load_busy", 32'(bus.busy), 32'd0);
        check("load_halted", 32'(bus.halted), 32'd0);

        // Host load / readback table
        for (int i = 0; i < 14; i++) begin
            bus.host_we    = vecs[i].we;
            bus.host_sel   = vecs[i].sel;
            bus.host_addr  = vecs[i].addr;
            bus.host_wdata = vecs[i].wdata;
            tick();
            if (vecs[i].chk) check($sformatf("host_vec%0d", i), bus.host_rdata, vecs[i].exp_rdata);
        end
        bus.host_we = 0;

        // Run LDC 5,7 ; HALT
        bus.host_go = 1;
        #1 check("go_no_start_in_load", 32'(bus.core_start), 32'd0);
        tick();
        bus.host_go = 0;
        check("start_core_start", 32'(bus.core_start), 32'd1);
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_cycles", 32'(bus.cycles), 32'd0);
        tick();
        check("run_core_start", 32'(bus.core_start), 32'd0);
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_instruc0", bus.instruc, OP_LDC_5_7);
        bus.wrEn = 1; bus.addr = 8'd5; bus.wrData = 8'h07; bus.pc = 8'd1;
        bus.host_we = 1; bus.host_sel = 1; bus.host_addr = 8'd9; bus.host_wdata = 32'hEE;
        tick();
        check("run_instruc1", bus.instruc, OP_HALT);
        check("run_host_rdata_hold", bus.host_rdata, 32'hDEADBEEF);
        check("run_cycles1", 32'(bus.cycles), 32'd1);
        bus.wrEn = 0; bus.host_we = 0; bus.core_done = 1;
        tick();
        bus.core_done = 0;
        check("halt_halted", 32'(bus.halted), 32'd1);
        check("halt_busy", 32'(bus.busy), 32'd0);
        check("halt_cycles", 32'(bus.cycles), 32'd2);
        check("halt_core_ack_idle", 32'(bus.core_ack), 32'd0);

        // HALTED: go and host writes ignored, reads allowed
        bus.host_go = 1; bus.host_sel = 1; bus.host_addr = 8'd5;
        bus.host_we = 1; bus.host_wdata = 32'h99;
        tick();
        bus.host_go = 0; bus.host_we = 0;
        check("halt_go_ignored", 32'(bus.halted), 32'd1);
        check("halt_read_dmem5", bus.host_rdata, 32'h00000007);
        bus.host_addr = 8'd9;
        tick();
        check("run_host_we_ignored", bus.host_rdata, 32'h00000066);
        bus.host_ack = 1;
        #1 check("ack_core_ack", 32'(bus.core_ack), 32'd1);
        bus.host_addr = 8'd5;
        tick();
        bus.host_ack = 0;
        #1 check("ack_core_ack_drop", 32'(bus.core_ack), 32'd0);
        check("ack_halted_drop", 32'(bus.halted), 32'd0);
        tick();
        check("halt_host_we_ignored", bus.host_rdata, 32'h00000007);

        // Watchdog on JMP 0
        bus.pc = 8'd0;
        bus.host_we = 1; bus.host_sel = 0; bus.host_addr = 8'd0; bus.host_wdata = OP_JMP_0;
        tick();
        bus.host_we = 0;
        bus.host_go = 1;
        tick();
        bus.host_go = 0;
        tick();
        n = 0;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            tick();
            n++;
        end
        check("wd_run_cycles", 32'(n), 32'd16);
        check("wd_timeout", 32'(bus.timeout), 32'd1);
        check("wd_core_reset", 32'(bus.core_reset), 32'd1);
        check("wd_cycles", 32'(bus.cycles), 32'd16);
        tick();
        check("wd_back_core_reset", 32'(bus.core_reset), 32'd0);
        check("wd_back_halted", 32'(bus.halted), 32'd0);
        check("wd_timeout_sticky", 32'(bus.timeout), 32'd1);

        // core_done on the watchdog's last cycle
        bus.host_go = 1;
        tick();
        bus.host_go = 0;
        check("go_clears_timeout", 32'(bus.timeout), 32'd0);
        tick();
        repeat (15) tick();
        bus.core_done = 1;
        tick();
        bus.core_done = 0;
        check("lim_halted", 32'(bus.halted), 32'd1);
        check("lim_timeout", 32'(bus.timeout), 32'd0);
        check("lim_cycles", 32'(bus.cycles), 32'd16);
        bus.host_ack = 1;
        tick();
        bus.host_ack = 0;

        // Core data port read-during-write, then reset mid-run
        bus.host_go = 1;
        tick();
        bus.host_go = 0;
        tick();
        bus.wrEn = 1; bus.rdEn = 1; bus.addr = 8'd4; bus.wrData = 8'h22;
        tick();
        check("core_rdw_old", 32'(bus.rdData), 32'h11);
        bus.wrEn = 0;
        tick();
        check("core_read_new", 32'(bus.rdData), 32'h22);
        bus.rdEn = 0; bus.addr = 8'd5;
        tick();
        check("core_rddata_hold", 32'(bus.rdData), 32'h22);
        reset = 1;
        tick();
        reset = 0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_core_reset", 32'(bus.core_reset), 32'd1);
        check("abort_cycles", 32'(bus.cycles), 32'd0);
        check("abort_rddata", 32'(bus.rdData), 32'd0);
        tick();
        check("abort_load", 32'(bus.core_reset), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
